// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: NUM_CH digits share one segment bus, with shadow/active
// data copies for tear-free frames. Optional macro SEG_LEAD_ZERO_BLANK_EN adds leading-zero suppression.
module seg_scan_mux #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int RESULT_WIDTH   = 7,
  parameter int SCAN_DIV       = 1000,
  parameter int ACTIVE_LOW_SEG = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dataIn,
  input  logic                         dataValid,
  input  logic [NUM_CH-1:0]            blankMask,
  output logic [RESULT_WIDTH-1:0]      segOut,
  output logic [NUM_CH-1:0]            digitSel,
  output logic                         frameStart
);

  localparam int   CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int   DW    = NUM_CH * DATA_WIDTH;
  localparam logic POL   = (ACTIVE_LOW_SEG != 0);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DW-1:0]           shadow_q, shadow_d;
  logic [DW-1:0]           active_q, active_d;
  logic [RESULT_WIDTH-1:0] seg_q, seg_d;
  logic [NUM_CH-1:0]       sel_q, sel_d;
  logic                    fs_q;

  logic                    tick;
  logic                    frame_end;
  logic [3:0]              nib [NUM_CH];
  logic [NUM_CH-1:0]       lz_blank;
  logic                    blank_cur;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Narrow digits are zero-extended so a single 16-entry decoder serves every width.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_nib
      assign nib[gi] = 4'(active_q[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

`ifdef SEG_LEAD_ZERO_BLANK_EN
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      run = run && (nib[k] == 4'h0);
      lz_blank[k] = run && (k != 0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign tick      = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == IDX_W'(NUM_CH - 1));
  assign blank_cur = blankMask[idx_q] | lz_blank[idx_q];

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = frame_end ? '0 : idx_q + 1'b1;
    shadow_d = dataValid ? dataIn : shadow_q;
    // A strobe landing on the frame boundary goes straight into the new frame.
    active_d = active_q;
    if (frame_end) active_d = dataValid ? dataIn : shadow_q;
    if (blank_cur) begin
      seg_d = {RESULT_WIDTH{POL}};
      sel_d = {NUM_CH{POL}};
    end else begin
      seg_d = RESULT_WIDTH'(hex7(nib[idx_q])) ^ {RESULT_WIDTH{POL}};
      sel_d = (NUM_CH'(1) << idx_q) ^ {NUM_CH{POL}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= {RESULT_WIDTH{POL}};
      sel_q    <= {NUM_CH{POL}};
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      fs_q     <= frame_end;
    end
  end

  assign segOut     = seg_q;
  assign digitSel   = sel_q;
  assign frameStart = fs_q;

endmodule
